// File: rtl/wide_addsub_seq_pkg.sv
// Shared encodings for the two-beat 64-bit add/sub sequencer.
// Op codes, FSM states and beat/word widths live here.
package wide_addsub_seq_pkg;

    localparam int HALF_W = 32;
    localparam int WORD_W = 2 * HALF_W;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_CMP = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    function automatic logic op_inverts_b(input op_e op);
        return (op == OP_SUB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/wide_addsub_seq_operand_mux_half.sv
// Selects the operand half for the current beat, inverts B for
// subtraction and generates the adder carry-in.
module operand_mux_half
    import wide_addsub_seq_pkg::*;
#(
    parameter int HALF_W = wide_addsub_seq_pkg::HALF_W
) (
    input  state_e                  state_i,
    input  op_e                     op_i,
    input  logic [2*HALF_W-1:0]     a_i,
    input  logic [2*HALF_W-1:0]     b_i,
    input  logic                    lo_c_i,
    input  logic                    carry_i,
    output logic [HALF_W-1:0]       add_a_o,
    output logic [HALF_W-1:0]       add_b_o,
    output logic                    add_cin_o
);

    logic [HALF_W-1:0] b_half;

    always_comb begin
        add_a_o   = '0;
        add_b_o   = '0;
        add_cin_o = 1'b0;
        b_half    = '0;
        unique case (state_i)
            ST_LO: begin
                add_a_o = a_i[HALF_W-1:0];
                b_half  = b_i[HALF_W-1:0];
                add_b_o = op_inverts_b(op_i) ? ~b_half : b_half;
                unique case (op_i)
                    OP_ADD:  add_cin_o = 1'b0;
                    OP_ADC:  add_cin_o = carry_i;
                    default: add_cin_o = 1'b1;
                endcase
            end
            ST_HI: begin
                add_a_o   = a_i[2*HALF_W-1:HALF_W];
                b_half    = b_i[2*HALF_W-1:HALF_W];
                add_b_o   = op_inverts_b(op_i) ? ~b_half : b_half;
                add_cin_o = lo_c_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wide_addsub_seq.sv
// Two-beat 64-bit ADD/SUB/ADC/CMP sequencer driving an external
// 32-bit adder, with valid/ready on both sides and sticky carry.
module wide_addsub_seq
    import wide_addsub_seq_pkg::*;
#(
    parameter int HALF_W = wide_addsub_seq_pkg::HALF_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_op,
    input  logic [2*HALF_W-1:0]     in_a,
    input  logic [2*HALF_W-1:0]     in_b,
    output logic [HALF_W-1:0]       add_a,
    output logic [HALF_W-1:0]       add_b,
    output logic                    add_cin,
    input  logic [HALF_W-1:0]       add_sum,
    input  logic                    add_carry,
    input  logic                    add_zero,
    input  logic                    add_neg,
    input  logic                    add_ovf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*HALF_W-1:0]     out_result,
    output logic                    out_c,
    output logic                    out_z,
    output logic                    out_n,
    output logic                    out_v,
    output logic                    carry_q
);

    state_e                 state_q, state_d;
    op_e                    op_q;
    logic [2*HALF_W-1:0]    a_q, b_q;
    logic [HALF_W-1:0]      lo_sum_q;
    logic                   lo_c_q, lo_z_q;
    logic [2*HALF_W-1:0]    res_q;
    logic                   c_q, z_q, n_q, v_q;
    logic                   valid_q;
    logic                   sticky_q;

    operand_mux_half #(
        .HALF_W (HALF_W)
    ) u_mux (
        .state_i   (state_q),
        .op_i      (op_q),
        .a_i       (a_q),
        .b_i       (b_q),
        .lo_c_i    (lo_c_q),
        .carry_i   (sticky_q),
        .add_a_o   (add_a),
        .add_b_o   (add_b),
        .add_cin_o (add_cin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_LO;
            ST_LO:   state_d = ST_HI;
            ST_HI:   state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == ST_IDLE);
        out_valid  = valid_q;
        out_result = res_q;
        out_c      = c_q;
        out_z      = z_q;
        out_n      = n_q;
        out_v      = v_q;
        carry_q    = sticky_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            lo_sum_q <= '0;
            lo_c_q   <= 1'b0;
            lo_z_q   <= 1'b0;
            res_q    <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            valid_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q  <= in_a;
                        b_q  <= in_b;
                        op_q <= op_e'(in_op);
                    end
                end
                ST_LO: begin
                    lo_sum_q <= add_sum;
                    lo_c_q   <= add_carry;
                    lo_z_q   <= add_zero;
                end
                ST_HI: begin
                    res_q    <= {add_sum, lo_sum_q};
                    c_q      <= add_carry;
                    z_q      <= lo_z_q & add_zero;
                    n_q      <= add_neg;
                    v_q      <= add_ovf;
                    valid_q  <= 1'b1;
                    sticky_q <= add_carry;
                end
                ST_DONE: begin
                    if (out_ready) valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_addsub_seq.sv
// Randomised self-checking bench for wide_addsub_seq with a
// behavioural 32-bit adder and a 64-bit arithmetic reference model.
module tb_wide_addsub_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [63:0] in_a, in_b;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_carry, add_zero, add_neg, add_ovf;
    logic        out_valid, out_ready;
    logic [63:0] out_result;
    logic        out_c, out_z, out_n, out_v, carry_q;

    int checks = 0;
    int errors = 0;
    logic mcq = 1'b0;

    typedef struct {
        logic [63:0] r;
        logic        c, z, n, v, cq;
        int          lat;
    } obs_t;

    wide_addsub_seq #(.HALF_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .add_carry  (add_carry),
        .add_zero   (add_zero),
        .add_neg    (add_neg),
        .add_ovf    (add_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_c      (out_c),
        .out_z      (out_z),
        .out_n      (out_n),
        .out_v      (out_v),
        .carry_q    (carry_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 32-bit ripple adder stand-in
    always_comb begin
        {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
        add_zero = (add_sum == 32'd0);
        add_neg  = add_sum[31];
        add_ovf  = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);
    end

    function automatic void ref_op(input logic [1:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input logic cq,
                                   output logic [63:0] r, output logic c,
                                   output logic z, output logic n, output logic v);
        logic [64:0] full;
        case (op)
            2'b00: full = {1'b0, a} + {1'b0, b};
            2'b10: full = {1'b0, a} + {1'b0, b} + {64'd0, cq};
            default: begin
                full[63:0] = a - b;
                full[64]   = (a >= b);
            end
        endcase
        r = full[63:0];
        c = full[64];
        z = (r == 64'd0);
        n = r[63];
        if (op == 2'b00 || op == 2'b10)
            v = (a[63] == b[63]) && (r[63] != a[63]);
        else
            v = (a[63] != b[63]) && (r[63] != a[63]);
    endfunction

    // One complete transaction; lat = -1 if never accepted, 10 if no result.
    task automatic xact(input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, output obs_t o);
        int n;
        n = 0;
        o.lat = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) o.lat = -1;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        @(negedge clk);
        in_valid = 1'b0;
        if (o.lat == 0) begin
            o.lat = 1;
            while (!out_valid && o.lat < 10) begin
                @(negedge clk);
                o.lat++;
            end
        end
        o.r = out_result;
        o.c = out_c;
        o.z = out_z;
        o.n = out_n;
        o.v = out_v;
        o.cq = carry_q;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mcq = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_c, out_z, out_n, out_v, carry_q} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000",
                     {out_valid, out_c, out_z, out_n, out_v, carry_q});
        end
        checks++;
        if (out_result !== 64'd0) begin
            errors++;
            $display("FAIL reset_result: got %h required 0", out_result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || {add_a, add_b, add_cin} !== 65'd0) begin
            errors++;
            $display("FAIL reset_idle: in_ready %b add_a %h add_b %h cin %b required 1/0/0/0",
                     in_ready, add_a, add_b, add_cin);
        end
        mcq = 1'b0;
    endtask

    task automatic test_op(input string name, input logic [1:0] op,
                           input logic [63:0] a, input logic [63:0] b);
        obs_t o;
        logic [63:0] er;
        logic ec, ez, en, ev;
        ref_op(op, a, b, mcq, er, ec, ez, en, ev);
        mcq = ec;
        xact(op, a, b, o);
        checks++;
        if (o.lat !== 3) begin
            errors++;
            $display("FAIL %s_latency: got %0d required 3", name, o.lat);
        end
        checks++;
        if (o.r !== er) begin
            errors++;
            $display("FAIL %s_result: got %h required %h", name, o.r, er);
        end
        checks++;
        if ({o.c, o.z, o.n, o.v, o.cq} !== {ec, ez, en, ev, ec}) begin
            errors++;
            $display("FAIL %s_flags(czn v cq): got %b required %b", name,
                     {o.c, o.z, o.n, o.v, o.cq}, {ec, ez, en, ev, ec});
        end
    endtask

    task automatic test_directed();
        test_op("add_wrap", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        test_op("sub", 2'b01, 64'd100, 64'd40);
        test_op("cmp_eq", 2'b11, 64'd55, 64'd55);
        test_op("sub_borrow", 2'b01, 64'd3, 64'd7);
        test_op("add_ovf", 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        test_op("add_lo_carry", 2'b00, 64'h0000_0000_FFFF_FFFF, 64'd1);
    endtask

    task automatic test_adc();
        test_op("add_nc", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        test_op("adc_c0", 2'b10, 64'd0, 64'd0);
        test_op("add_c1", 2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        test_op("adc_c1", 2'b10, 64'd0, 64'd0);
        test_op("cmp_cq", 2'b11, 64'd1, 64'd2);
        test_op("adc_after_cmp", 2'b10, 64'd10, 64'd20);
    endtask

    task automatic test_beats();
        logic [63:0] a, b;
        logic [32:0] lo;
        logic [32:0] hi;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        lo = {1'b0, a[31:0]} + {1'b0, ~b[31:0]} + 33'd1;
        hi = {1'b0, a[63:32]} + {1'b0, ~b[63:32]} + {32'd0, lo[32]};
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b01; in_a = a; in_b = b;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({add_a, add_b, add_cin} !== {a[31:0], ~b[31:0], 1'b1}) begin
            errors++;
            $display("FAIL beat_lo: got %h %h %b required %h %h 1",
                     add_a, add_b, add_cin, a[31:0], ~b[31:0]);
        end
        @(negedge clk);
        checks++;
        if ({add_a, add_b, add_cin} !== {a[63:32], ~b[63:32], lo[32]}) begin
            errors++;
            $display("FAIL beat_hi: got %h %h %b required %h %h %b",
                     add_a, add_b, add_cin, a[63:32], ~b[63:32], lo[32]);
        end
        @(negedge clk);
        checks++;
        if ({add_a, add_b, add_cin} !== 65'd0 || out_result !== {hi[31:0], lo[31:0]}) begin
            errors++;
            $display("FAIL beat_done: adder %h %h %b result %h required 0 0 0 %h",
                     add_a, add_b, add_cin, out_result, {hi[31:0], lo[31:0]});
        end
        mcq = hi[32];
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [63:0] a1, b1, a2, b2, er, snap;
        logic ec, ez, en, ev;
        int lat;
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_a = a1; in_b = b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        ref_op(2'b00, a1, b1, mcq, er, ec, ez, en, ev);
        mcq = ec;
        checks++;
        if (out_valid !== 1'b1 || out_result !== er) begin
            errors++;
            $display("FAIL bp_first: valid %b result %h required 1 %h", out_valid, out_result, er);
        end
        snap = out_result;
        in_valid = 1'b1; in_op = 2'b01; in_a = a2; in_b = b2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== snap) begin
                errors++;
                $display("FAIL bp_hold%0d: valid %b in_ready %b result %h required 1 0 %h",
                         i, out_valid, in_ready, out_result, snap);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== snap) begin
            errors++;
            $display("FAIL bp_release: valid %b in_ready %b result %h required 0 1 %h",
                     out_valid, in_ready, out_result, snap);
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        ref_op(2'b01, a2, b2, mcq, er, ec, ez, en, ev);
        mcq = ec;
        checks++;
        if (lat !== 3 || out_result !== er || out_c !== ec) begin
            errors++;
            $display("FAIL bp_second: lat %0d result %h c %b required 3 %h %b",
                     lat, out_result, out_c, er, ec);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        test_op("pre_rst", 2'b00, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000);
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_a = 64'd9; in_b = 64'd9;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        mcq = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || carry_q !== 1'b0 || out_result !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid: valid %b carry_q %b result %h required 0 0 0",
                     out_valid, carry_q, out_result);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_hold: valid %b required 0", out_valid);
        end
        rst_n = 1'b1;
        test_op("post_rst_adc", 2'b10, 64'd5, 64'd7);
    endtask

    task automatic test_random();
        logic [63:0] a, b;
        logic [1:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 8 == 1) b = a;
            if (i % 8 == 3) a = 64'hFFFF_FFFF_FFFF_FFFF;
            if (i % 8 == 5) b = {32'd0, 32'hFFFF_FFFF};
            test_op("rand", op, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_adc();
        test_beats();
        test_backpressure();
        test_reset_mid();
        do_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
